// File: rtl/adder_op_sequencer.sv
// Operand sequencer for the 64-bit DPI adder: buffers operand pairs and drives them on registered lines.
// It captures each sum one cycle later and returns it with an unsigned carry-out over a valid/ready stream.
module adder_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_carry,
  output logic [31:0]  done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [W-1:0]  r_mem_a [DEPTH];
  logic [W-1:0]  r_mem_b [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [W-1:0]  r_add_a;
  logic [W-1:0]  r_add_b;
  logic [W-1:0]  r_out_result;
  logic          r_out_carry;
  logic          r_out_valid;
  logic [31:0]   r_done_count;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_handshake;

  // No bypass: a full FIFO refuses input even when the FSM pops on the same edge.
  assign in_ready    = !rst && (r_count < CNT_FULL);
  assign w_push      = in_valid && in_ready;
  assign w_empty     = (r_count == '0);
  assign w_handshake = (r_state == HOLD) && out_ready;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = DRIVE;
        end
      end
      DRIVE: w_next_state = HOLD;
      HOLD: begin
        if (out_ready) begin
          w_pop        = !w_empty;
          w_next_state = w_empty ? IDLE : DRIVE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Operands sit registered for the whole DRIVE cycle so the adder settles before capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_done_count <= '0;
    end else begin
      if (w_pop) begin
        r_add_a <= r_mem_a[r_rd_ptr];
        r_add_b <= r_mem_b[r_rd_ptr];
      end
      if (r_state == DRIVE) begin
        r_out_result <= add_result;
        r_out_carry  <= (add_result < r_add_a);
        r_out_valid  <= 1'b1;
      end
      if (w_handshake) begin
        r_done_count <= r_done_count + 32'd1;
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_valid  = r_out_valid;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Scoreboard bench for adder_op_sequencer; a behavioural adder closes the add_a/add_b -> add_result loop.
module tb_adder_op_sequencer;

  typedef struct packed {
    logic [63:0] res;
    logic        carry;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_carry;
  logic [31:0] done_count;

  exp_t sbq[$];
  int   nAssert = 0;
  int   nFail   = 0;
  int   cyc     = 0;
  int   lastHs  = 0;
  bit   rateArm = 1'b0;
  bit   havePrev = 1'b0;

  adder_op_sequencer #(.DEPTH(4), .W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .done_count (done_count)
  );

  // Stand-in for the DPI adder stage.
  assign add_result = add_a + add_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nAssert++;
    nFail++;
    $display("[TB] FAIL %s: bound expired, got nothing, required an event", name);
  endtask

  // Called at a negedge; leaves in_valid high on return so back-to-back calls push every cycle.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failNow("accept_timeout");
    end else begin
      s = {1'b0, a} + {1'b0, b};
      sbq.push_back({s[63:0], s[64]});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((sbq.size() != 0 || out_valid) && n < 100);
    if (sbq.size() != 0 || out_valid) failNow("drain_timeout");
    @(negedge clk);
  endtask

  // Monitor: a handshake seen here completes on the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          nAssert++;
          nFail++;
          $display("[TB] FAIL unexpected_result: got 0x%0h, required no result", out_result);
        end else begin
          e = sbq.pop_front();
          checkOutput("result", out_result, e.res);
          checkOutput("carry", 64'(out_carry), 64'(e.carry));
          if (rateArm) begin
            if (havePrev) checkOutput("rate_cycles", 64'(cyc - lastHs), 64'd2);
            lastHs = cyc;
            havePrev = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_add_a", add_a, 64'd0);
    checkOutput("rst_done_count", 64'(done_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] single op");
    out_ready = 1'b1;
    applyStimulus(64'd5, 64'd7);
    in_valid = 1'b0;
    checkOutput("lat_e0_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_e1_add_a", add_a, 64'd5);
    checkOutput("lat_e1_add_b", add_b, 64'd7);
    checkOutput("lat_e1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_e2_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_e2_result", out_result, 64'd12);
    waitDrain();
    checkOutput("single_done_count", 64'(done_count), 64'd1);

    $display("[TB] wrap");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("wrap_done_count", 64'(done_count), 64'd3);

    $display("[TB] fill and backpressure");
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(64'(i), 64'(i));
    in_a = 64'd6;
    in_b = 64'd6;
    for (int k = 0; k < 3; k++) begin
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      checkOutput("held_valid", 64'(out_valid), 64'd1);
      checkOutput("held_result", out_result, 64'd2);
      @(negedge clk);
    end
    rateArm = 1'b1;
    havePrev = 1'b0;
    out_ready = 1'b1;
    applyStimulus(64'd6, 64'd6);
    in_valid = 1'b0;
    waitDrain();
    rateArm = 1'b0;
    checkOutput("fill_done_count", 64'(done_count), 64'd9);

    $display("[TB] simultaneous push and pop");
    out_ready = 1'b0;
    applyStimulus(64'd100, 64'd200);
    applyStimulus(64'h1234, 64'd1);
    applyStimulus(64'd7, 64'd8);
    checkOutput("pre_swap_count", 64'(dut.r_count), 64'd2);
    out_ready = 1'b1;
    applyStimulus(64'd40, 64'd2);
    in_valid = 1'b0;
    checkOutput("swap_count", 64'(dut.r_count), 64'd2);
    checkOutput("swap_add_a", add_a, 64'h1234);
    waitDrain();

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    applyStimulus(64'd10, 64'd20);
    applyStimulus(64'd11, 64'd21);
    applyStimulus(64'd12, 64'd22);
    applyStimulus(64'd13, 64'd23);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_queued", 64'(dut.r_count), 64'd3);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    checkOutput("mid_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid_add_a", add_a, 64'd0);
    checkOutput("mid_add_b", add_b, 64'd0);
    checkOutput("mid_out_result", out_result, 64'd0);
    checkOutput("mid_out_carry", 64'(out_carry), 64'd0);
    checkOutput("mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_done_count", 64'(done_count), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("flushed_count", 64'(dut.r_count), 64'd0);
    applyStimulus(64'd3, 64'd4);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("post_rst_done_count", 64'(done_count), 64'd1);

    $display("[TB] counter wrap");
    force dut.r_done_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_done_count;
    checkOutput("forced_done_count", 64'(done_count), 64'hFFFF_FFFF);
    @(negedge clk);
    applyStimulus(64'd1, 64'd1);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("wrapped_done_count", 64'(done_count), 64'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
